// File: rtl/mac_dot_sequencer_pkg.sv
// Shared types and default sizing for the dual-lane multiply-add sequencer.
package mac_seq_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DRAIN  = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam int OP_W      = 8;
   localparam int NUM_LANES = 2;
   localparam int PROD_W    = 17;

   localparam int DEF_MULT_LATENCY = 3;
   localparam int DEF_LEN_W        = 12;
   localparam int DEF_ACC_W        = 32;

endpackage

// File: rtl/mac_dot_sequencer_if.sv
// Job config, operand stream and result handshake bundle of the sequencer.
interface mac_dot_sequencer_if
   import mac_seq_pkg::*;
#(
   parameter int LEN_W = DEF_LEN_W,
   parameter int ACC_W = DEF_ACC_W
);

   logic                    cfg_valid;
   logic                    cfg_ready;
   logic [LEN_W-1:0]        cfg_len;
   logic                    in_valid;
   logic                    in_ready;
   logic signed [OP_W-1:0]  in_a0;
   logic signed [OP_W-1:0]  in_b0;
   logic signed [OP_W-1:0]  in_a1;
   logic signed [OP_W-1:0]  in_b1;
   logic                    out_valid;
   logic                    out_ready;
   logic [ACC_W-1:0]        out_result;
   logic                    busy;

   modport slave (
      input  cfg_valid, cfg_len, in_valid, in_a0, in_b0, in_a1, in_b1, out_ready,
      output cfg_ready, in_ready, out_valid, out_result, busy
   );

   modport master (
      output cfg_valid, cfg_len, in_valid, in_a0, in_b0, in_a1, in_b1, out_ready,
      input  cfg_ready, in_ready, out_valid, out_result, busy
   );

endinterface

// File: rtl/mac_dot_sequencer_pair_pipe.sv
// Two signed 8x8 products summed, then MULT_LATENCY register stages with a
// parallel valid tag. Reset clears the tags only; data stages free-run.
module mac_pair_pipe
   import mac_seq_pkg::*;
#(
   parameter int MULT_LATENCY = DEF_MULT_LATENCY
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     in_tag,
   input  logic signed [OP_W-1:0]   a0,
   input  logic signed [OP_W-1:0]   b0,
   input  logic signed [OP_W-1:0]   a1,
   input  logic signed [OP_W-1:0]   b1,
   output logic                     out_tag,
   output logic signed [PROD_W-1:0] out_sum
);

   logic [NUM_LANES-1:0][OP_W-1:0]   op_a;
   logic [NUM_LANES-1:0][OP_W-1:0]   op_b;
   logic [NUM_LANES-1:0][2*OP_W-1:0] prod;
   logic [PROD_W-1:0]                sum_in;

   logic [MULT_LATENCY:1]              vld_pipe;
   logic [MULT_LATENCY:1][PROD_W-1:0]  sum_pipe;

   assign op_a = {a1, a0};
   assign op_b = {b1, b0};

   for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      assign prod[g] = 16'($signed(op_a[g])) * 16'($signed(op_b[g]));
   end

   // One extra bit keeps (-128*-128)*2 from overflowing.
   assign sum_in = {prod[0][2*OP_W-1], prod[0]} + {prod[1][2*OP_W-1], prod[1]};

   always_ff @(posedge clock) begin
      if (reset) begin
         vld_pipe <= '0;
      end else begin
         vld_pipe[1] <= in_tag;
         for (int i = 2; i <= MULT_LATENCY; i++) vld_pipe[i] <= vld_pipe[i-1];
      end
   end

   always_ff @(posedge clock) begin
      sum_pipe[1] <= sum_in;
      for (int i = 2; i <= MULT_LATENCY; i++) sum_pipe[i] <= sum_pipe[i-1];
   end

   assign out_tag = vld_pipe[MULT_LATENCY];
   assign out_sum = sum_pipe[MULT_LATENCY];

endmodule

// File: rtl/mac_dot_sequencer.sv
// Job sequencer: takes a beat count, streams operand beats through the
// multiply-add pipe, accumulates the sums and returns the dot product.
module mac_dot_sequencer
   import mac_seq_pkg::*;
#(
   parameter int MULT_LATENCY = DEF_MULT_LATENCY,
   parameter int LEN_W        = DEF_LEN_W,
   parameter int ACC_W        = DEF_ACC_W
) (
   input  logic          clock,
   input  logic          reset,
   mac_dot_sequencer_if.slave bus
);

   localparam int INF_W = $clog2(MULT_LATENCY + 2);

   state_t                    state;
   state_t                    state_nxt;
   logic [LEN_W-1:0]          len_q;
   logic [LEN_W-1:0]          beat_cnt;
   logic [ACC_W-1:0]          acc;
   logic [ACC_W-1:0]          sum_ext;
   logic [INF_W-1:0]          inflight;
   logic                      cfg_fire;
   logic                      in_fire;
   logic                      out_fire;
   logic                      last_beat;
   logic                      pipe_tag;
   logic signed [PROD_W-1:0]  pipe_sum;

   assign bus.cfg_ready  = (state == IDLE);
   assign bus.in_ready   = (state == STREAM);
   assign bus.out_valid  = (state == DONE);
   assign bus.busy       = (state != IDLE);
   assign bus.out_result = acc;

   assign cfg_fire  = bus.cfg_valid & bus.cfg_ready;
   assign in_fire   = bus.in_valid  & bus.in_ready;
   assign out_fire  = bus.out_valid & bus.out_ready;
   assign last_beat = (beat_cnt == len_q - LEN_W'(1));
   assign sum_ext   = {{(ACC_W-PROD_W){pipe_sum[PROD_W-1]}}, pipe_sum};

   mac_pair_pipe #(
      .MULT_LATENCY (MULT_LATENCY)
   ) u_pipe (
      .clock   (clock),
      .reset   (reset),
      .in_tag  (in_fire),
      .a0      (bus.in_a0),
      .b0      (bus.in_b0),
      .a1      (bus.in_a1),
      .b1      (bus.in_b1),
      .out_tag (pipe_tag),
      .out_sum (pipe_sum)
   );

   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // DRAIN ends when the only beat still in flight is the one leaving now,
   // so its sum lands in acc on the same edge that enters DONE.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (cfg_fire) state_nxt = (bus.cfg_len == '0) ? DONE : STREAM;
         STREAM:  if (in_fire && last_beat) state_nxt = DRAIN;
         DRAIN:   if (inflight == INF_W'(pipe_tag)) state_nxt = DONE;
         DONE:    if (out_fire) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         len_q    <= '0;
         beat_cnt <= '0;
         acc      <= '0;
      end else if (cfg_fire) begin
         len_q    <= bus.cfg_len;
         beat_cnt <= '0;
         acc      <= '0;
      end else begin
         if (in_fire)  beat_cnt <= beat_cnt + LEN_W'(1);
         if (pipe_tag) acc      <= acc + sum_ext;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         inflight <= '0;
      end else begin
         case ({in_fire, pipe_tag})
            2'b10:   inflight <= inflight + INF_W'(1);
            2'b01:   inflight <= inflight - INF_W'(1);
            default: inflight <= inflight;
         endcase
      end
   end

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Randomized and directed checks of the dot-product sequencer against an
// arithmetic reference of the job result and its output latency.
module tb_mac_dot_sequencer;
   import mac_seq_pkg::*;

   localparam int L = DEF_MULT_LATENCY;

   logic clock = 1'b0;
   logic reset = 1'b1;

   mac_dot_sequencer_if bus ();

   mac_dot_sequencer #(
      .MULT_LATENCY (L),
      .LEN_W        (DEF_LEN_W),
      .ACC_W        (DEF_ACC_W)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   logic signed [7:0] ga0 [64];
   logic signed [7:0] gb0 [64];
   logic signed [7:0] ga1 [64];
   logic signed [7:0] gb1 [64];
   int gap_mode = 0;
   bit pat [8] = '{1, 0, 0, 1, 1, 0, 1, 1};

   function automatic int ref_dot(input int len);
      int s = 0;
      for (int i = 0; i < len; i++)
         s += int'(ga0[i]) * int'(gb0[i]) + int'(ga1[i]) * int'(gb1[i]);
      return s;
   endfunction

   task automatic fill_const(input int len, input int v0, input int w0, input int v1, input int w1);
      for (int i = 0; i < len; i++) begin
         ga0[i] = 8'(v0); gb0[i] = 8'(w0); ga1[i] = 8'(v1); gb1[i] = 8'(w1);
      end
   endtask

   task automatic fill_rand(input int len);
      for (int i = 0; i < len; i++) begin
         ga0[i] = 8'($urandom); gb0[i] = 8'($urandom);
         ga1[i] = 8'($urandom); gb1[i] = 8'($urandom);
      end
   endtask

   task automatic start_job(input string name, input int len);
      checks++;
      if (bus.cfg_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s cfg_ready before job: got %b want 1", name, bus.cfg_ready);
      end
      bus.cfg_valid = 1'b1;
      bus.cfg_len   = 12'(len);
      @(negedge clock);
      bus.cfg_valid = 1'b0;
   endtask

   task automatic stream(input string name, input int len, output logic [31:0] res);
      int cyc = 0, idx = 0, last = -1, bad_rdy = 0, lat;
      bit got = 0, rdy, vld;
      while (cyc < 300) begin
         if (bus.out_valid === 1'b1) begin got = 1; break; end
         rdy = bus.in_ready;
         if (rdy != (idx < len)) bad_rdy++;
         if (idx < len) begin
            case (gap_mode)
               0:       vld = 1'b1;
               1:       vld = pat[cyc % 8];
               default: vld = ($urandom_range(0, 3) != 0);
            endcase
         end else begin
            vld = 1'b1;  // junk beats while the sequencer must not take them
         end
         bus.in_valid = vld;
         if (idx < len && vld) begin
            bus.in_a0 = ga0[idx]; bus.in_b0 = gb0[idx];
            bus.in_a1 = ga1[idx]; bus.in_b1 = gb1[idx];
         end else begin
            bus.in_a0 = 8'($urandom); bus.in_b0 = 8'($urandom);
            bus.in_a1 = 8'($urandom); bus.in_b1 = 8'($urandom);
         end
         if (vld && rdy && idx < len) begin
            idx++;
            if (idx == len) last = cyc;
         end
         @(negedge clock);
         cyc++;
      end
      bus.in_valid = 1'b0;
      res = bus.out_result;
      checks++;
      if (!got || idx != len) begin
         errors++;
         $display("FAIL %s completion: out_valid seen %0d beats taken %0d want %0d", name, got, idx, len);
      end
      checks++;
      if (bad_rdy != 0) begin
         errors++;
         $display("FAIL %s in_ready window: %0d wrong cycles want 0", name, bad_rdy);
      end
      lat = (len == 0) ? cyc : cyc - last;
      checks++;
      if (lat != ((len == 0) ? 0 : L + 1)) begin
         errors++;
         $display("FAIL %s latency: got %0d want %0d", name, lat, (len == 0) ? 0 : L + 1);
      end
      checks++;
      if (res !== 32'(ref_dot(len))) begin
         errors++;
         $display("FAIL %s result: got %0d want %0d", name, $signed(res), ref_dot(len));
      end
   endtask

   task automatic hold_result(input string name, input logic [31:0] res, input int hold);
      int bad = 0;
      for (int i = 0; i < hold; i++) begin
         bus.out_ready = 1'b0;
         if (bus.out_valid !== 1'b1 || bus.busy !== 1'b1 || bus.out_result !== res) bad++;
         @(negedge clock);
      end
      if (hold > 0) begin
         checks++;
         if (bad != 0) begin
            errors++;
            $display("FAIL %s backpressure hold: %0d unstable cycles want 0", name, bad);
         end
      end
   endtask

   task automatic finish(input string name, input logic [31:0] res, input int hold);
      hold_result(name, res, hold);
      bus.out_ready = 1'b1;
      @(negedge clock);
      bus.out_ready = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.cfg_ready !== 1'b1 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL %s return to idle: valid %b cfg_ready %b busy %b want 0 1 0",
                  name, bus.out_valid, bus.cfg_ready, bus.busy);
      end
   endtask

   task automatic check_idle_outputs(input string name);
      checks++;
      if (bus.cfg_ready !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 ||
          bus.out_result !== 32'd0 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL %s reset outputs: cfg_ready %b in_ready %b out_valid %b result %h busy %b want 1 0 0 0 0",
                  name, bus.cfg_ready, bus.in_ready, bus.out_valid, bus.out_result, bus.busy);
      end
   endtask

   task automatic test_reset();
      bus.cfg_valid = 0; bus.cfg_len = '0; bus.in_valid = 0; bus.out_ready = 0;
      bus.in_a0 = '0; bus.in_b0 = '0; bus.in_a1 = '0; bus.in_b1 = '0;
      reset = 1'b1;
      repeat (3) @(negedge clock);
      check_idle_outputs("reset");
      reset = 1'b0;
      @(negedge clock);
      check_idle_outputs("after_reset");
   endtask

   task automatic test_basic();
      logic [31:0] r;
      gap_mode = 0;
      fill_const(4, 1, 1, 1, 1);
      start_job("basic", 4);
      stream("basic", 4, r);
      checks++;
      if (r !== 32'd8) begin
         errors++;
         $display("FAIL basic literal: got %0d want 8", r);
      end
      finish("basic", r, 0);
   endtask

   task automatic test_signed_extremes();
      logic [31:0] r;
      gap_mode = 0;
      fill_const(3, -128, -128, -128, -128);
      start_job("neg_sq", 3);
      stream("neg_sq", 3, r);
      checks++;
      if (r !== 32'd98304) begin
         errors++;
         $display("FAIL neg_sq literal: got %0d want 98304", r);
      end
      finish("neg_sq", r, 0);
      fill_const(1, -128, 127, 0, 0);
      start_job("neg_pos", 1);
      stream("neg_pos", 1, r);
      checks++;
      if (r !== 32'hFFFF_C080) begin
         errors++;
         $display("FAIL neg_pos literal: got %h want ffffc080", r);
      end
      finish("neg_pos", r, 0);
   endtask

   task automatic test_zero_len();
      logic [31:0] r;
      gap_mode = 0;
      start_job("zero", 0);
      stream("zero", 0, r);
      finish("zero", r, 2);
   endtask

   task automatic test_gapped();
      logic [31:0] r;
      gap_mode = 1;
      fill_rand(5);
      start_job("gapped", 5);
      stream("gapped", 5, r);
      finish("gapped", r, 0);
      gap_mode = 0;
   endtask

   task automatic test_backpressure_overlap();
      logic [31:0] r;
      gap_mode = 0;
      fill_rand(2);
      start_job("bp", 2);
      stream("bp", 2, r);
      hold_result("bp", r, 10);
      bus.out_ready = 1'b1;
      bus.cfg_valid = 1'b1;
      bus.cfg_len   = 12'd3;
      @(negedge clock);
      bus.out_ready = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.cfg_ready !== 1'b1) begin
         errors++;
         $display("FAIL overlap first cycle: valid %b busy %b cfg_ready %b want 0 0 1",
                  bus.out_valid, bus.busy, bus.cfg_ready);
      end
      fill_rand(3);
      @(negedge clock);
      bus.cfg_valid = 1'b0;
      checks++;
      if (bus.busy !== 1'b1 || bus.cfg_ready !== 1'b0) begin
         errors++;
         $display("FAIL overlap accept: busy %b cfg_ready %b want 1 0", bus.busy, bus.cfg_ready);
      end
      stream("overlap", 3, r);
      finish("overlap", r, 0);
   endtask

   task automatic test_reset_mid_job();
      logic [31:0] r;
      int pulses = 0;
      fill_rand(6);
      start_job("abort", 6);
      for (int i = 0; i < 2; i++) begin
         bus.in_valid = 1'b1;
         bus.in_a0 = ga0[i]; bus.in_b0 = gb0[i]; bus.in_a1 = ga1[i]; bus.in_b1 = gb1[i];
         @(negedge clock);
      end
      bus.in_valid = 1'b0;
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      check_idle_outputs("abort");
      for (int i = 0; i < 10; i++) begin
         if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) pulses++;
         @(negedge clock);
      end
      checks++;
      if (pulses != 0) begin
         errors++;
         $display("FAIL abort quiet: %0d active cycles want 0", pulses);
      end
      gap_mode = 0;
      fill_const(2, 2, 2, 2, 2);
      start_job("post_abort", 2);
      stream("post_abort", 2, r);
      checks++;
      if (r !== 32'd16) begin
         errors++;
         $display("FAIL post_abort literal: got %0d want 16", r);
      end
      finish("post_abort", r, 0);
   endtask

   task automatic test_random();
      logic [31:0] r;
      int len;
      gap_mode = 2;
      for (int j = 0; j < 6; j++) begin
         len = $urandom_range(1, 20);
         fill_rand(len);
         start_job("random", len);
         stream("random", len, r);
         finish("random", r, $urandom_range(0, 3));
      end
      gap_mode = 0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_signed_extremes();
      test_zero_len();
      test_gapped();
      test_backpressure_overlap();
      test_reset_mid_job();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
